// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I-subset core: opcode constants, fetch FSM
// states, and the legal-opcode check used by both fetch and controller.
package riscv_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALT
  } fetch_state_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    return op inside {OP_R_TYPE, OP_I_TYPE, OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: resets to RESET_PC, advances by one word when enabled.
module pc_counter #(
  parameter int unsigned         ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] pc
);

  // Carry out of the top bit is dropped, so the PC wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (en) begin
      pc <= pc + ADDR_W'(4);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: fetches words over req/ack, issues them over
// valid/ready, and halts permanently on an unsupported opcode.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       Instruction,
  output logic [6:0]        Opcode,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal_op
);

  fetch_state_t state;
  logic [31:0]  ir;
  logic         pc_en;

  assign pc_en = (state == ST_ISSUE) && instr_ready;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_en),
    .pc    (pc)
  );

  // Outputs are registered alongside the state so each one is set on the
  // same edge the FSM enters the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ir          <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            if (is_legal_op(imem_rdata[6:0])) begin
              state       <= ST_ISSUE;
              instr_valid <= 1'b1;
            end else begin
              state      <= ST_HALT;
              halted     <= 1'b1;
              illegal_op <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            state       <= ST_FETCH;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign Instruction = ir;
  assign Opcode      = ir[6:0];

endmodule
